// File: rtl/cv32e40p_tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// cv32e40p_tb_ram_arbiter
//
// Purpose:
//   Shares the single access port of the testbench RAM between the core's
//   instruction and data OBI ports. Round-robin on conflicts, one access per
//   cycle. The RAM has a 1-cycle read latency, so every grant produces exactly
//   one rvalid to the winning requester on the following cycle.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   instr_req_i / instr_addr_i      fetch request and byte address
//   instr_gnt_o / instr_rvalid_o / instr_rdata_o   fetch handshake and data
//   data_req_i / data_addr_i / data_we_i / data_be_i / data_wdata_i
//                                   load/store request
//   data_gnt_o / data_rvalid_o / data_rdata_o      load/store handshake and data
//   ram_en_o / ram_addr_o / ram_we_o / ram_be_o / ram_wdata_o   RAM request
//   ram_rdata_i                     RAM read data, valid the cycle after ram_en_o
//
// Configuration:
//   TB_ARB_STALL_INJECT_EN  when defined, a 16-bit Fibonacci LFSR (taps
//                           16,14,13,11) seeded with STALL_SEED[15:0] blocks
//                           grants in cycles where LFSR[3:0] & STALL_MASK != 0.
// -----------------------------------------------------------------------------
module cv32e40p_tb_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 22,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] STALL_SEED = 32'hACE1,
    parameter logic [3:0]  STALL_MASK = 4'b0011
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    localparam logic OWNER_INSTR = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    logic                  last_r;       // winner of the most recent conflict
    logic                  resp_v_r;     // a RAM access was issued last cycle
    logic                  resp_own_r;   // owner of last cycle's access
    logic                  resp_we_r;    // last cycle's access was a store
    logic                  stall_s;
    logic                  conflict_s;
    logic                  instr_win_s;
    logic                  data_win_s;
    logic                  ram_en_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic                  ram_we_s;
    logic [3:0]            ram_be_s;
    logic [DATA_WIDTH-1:0] ram_wdata_s;
    logic                  instr_rvalid_s;
    logic                  data_rvalid_s;
    logic [DATA_WIDTH-1:0] instr_rdata_s;
    logic [DATA_WIDTH-1:0] data_rdata_s;

`ifdef TB_ARB_STALL_INJECT_EN
    logic [15:0] lfsr_r;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1; a non-zero
    // state never maps to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic fb;
        fb = cur[0] ^ cur[2] ^ cur[3] ^ cur[5];
        return {fb, cur[15:1]};
    endfunction

    // Stall-injection LFSR, free running outside reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_r <= STALL_SEED[15:0];
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign stall_s = ((lfsr_r[3:0] & STALL_MASK) != 4'b0000);

    logic unused_s;
    assign unused_s = ^{instr_addr_i[1:0], data_addr_i[1:0], STALL_SEED[31:16]};
`else
    assign stall_s = 1'b0;

    logic unused_s;
    assign unused_s = ^{instr_addr_i[1:0], data_addr_i[1:0], STALL_SEED, STALL_MASK};
`endif

    assign conflict_s = instr_req_i & data_req_i & ~rst_i & ~stall_s;

    // Grant selection: single requester wins outright, conflicts go to the
    // requester that lost the previous conflict
    always_comb begin
        instr_win_s = 1'b0;
        data_win_s  = 1'b0;
        if (rst_i || stall_s) begin
            instr_win_s = 1'b0;
            data_win_s  = 1'b0;
        end else if (instr_req_i && data_req_i) begin
            if (last_r == OWNER_INSTR) begin
                data_win_s = 1'b1;
            end else begin
                instr_win_s = 1'b1;
            end
        end else if (instr_req_i) begin
            instr_win_s = 1'b1;
        end else if (data_req_i) begin
            data_win_s = 1'b1;
        end else begin
            instr_win_s = 1'b0;
            data_win_s  = 1'b0;
        end
    end

    // Conflict-winner register; single-requester grants leave it untouched
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_r <= OWNER_INSTR;
        end else if (conflict_s) begin
            last_r <= data_win_s ? OWNER_DATA : OWNER_INSTR;
        end else begin
            last_r <= last_r;
        end
    end

    // RAM request mux; all fields are zero when nothing is granted
    always_comb begin
        ram_en_s    = 1'b0;
        ram_addr_s  = {ADDR_WIDTH{1'b0}};
        ram_we_s    = 1'b0;
        ram_be_s    = 4'h0;
        ram_wdata_s = {DATA_WIDTH{1'b0}};
        case ({instr_win_s, data_win_s})
            2'b10: begin
                ram_en_s    = 1'b1;
                ram_addr_s  = {instr_addr_i[ADDR_WIDTH-1:2], 2'b00};
                ram_we_s    = 1'b0;
                ram_be_s    = 4'hF;
                ram_wdata_s = {DATA_WIDTH{1'b0}};
            end
            2'b01: begin
                ram_en_s    = 1'b1;
                ram_addr_s  = {data_addr_i[ADDR_WIDTH-1:2], 2'b00};
                ram_we_s    = data_we_i;
                ram_be_s    = data_be_i;
                ram_wdata_s = data_wdata_i;
            end
            default: begin
                ram_en_s    = 1'b0;
                ram_addr_s  = {ADDR_WIDTH{1'b0}};
                ram_we_s    = 1'b0;
                ram_be_s    = 4'h0;
                ram_wdata_s = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Response pipeline: remembers who owns the RAM data arriving next cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_v_r   <= 1'b0;
            resp_own_r <= OWNER_INSTR;
            resp_we_r  <= 1'b0;
        end else begin
            resp_v_r   <= ram_en_s;
            resp_own_r <= data_win_s ? OWNER_DATA : OWNER_INSTR;
            resp_we_r  <= data_win_s & data_we_i;
        end
    end

    // Response routing; gated by rst_i so a response due during reset is dropped
    always_comb begin
        instr_rvalid_s = resp_v_r & (resp_own_r == OWNER_INSTR) & ~rst_i;
        data_rvalid_s  = resp_v_r & (resp_own_r == OWNER_DATA) & ~rst_i;
        if (instr_rvalid_s) begin
            instr_rdata_s = ram_rdata_i;
        end else begin
            instr_rdata_s = {DATA_WIDTH{1'b0}};
        end
        if (data_rvalid_s && !resp_we_r) begin
            data_rdata_s = ram_rdata_i;
        end else begin
            data_rdata_s = {DATA_WIDTH{1'b0}};
        end
    end

    assign instr_gnt_o    = instr_win_s;
    assign data_gnt_o     = data_win_s;
    assign ram_en_o       = ram_en_s;
    assign ram_addr_o     = ram_addr_s;
    assign ram_we_o       = ram_we_s;
    assign ram_be_o       = ram_be_s;
    assign ram_wdata_o    = ram_wdata_s;
    assign instr_rvalid_o = instr_rvalid_s;
    assign data_rvalid_o  = data_rvalid_s;
    assign instr_rdata_o  = instr_rdata_s;
    assign data_rdata_o   = data_rdata_s;

endmodule

// File: tb/tb_cv32e40p_tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cv32e40p_tb_ram_arbiter. A behavioural RAM with
// 1-cycle read latency sits behind the arbiter; a reference model predicts
// grants each cycle and pushes the expected response into a scoreboard queue,
// which is popped and compared when the response is due.
// -----------------------------------------------------------------------------
module tb_cv32e40p_tb_ram_arbiter;

    typedef struct packed {
        logic        own;   // 0 = instr, 1 = data
        logic [31:0] data;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        instr_req;
    logic [21:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        data_req;
    logic [21:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        ram_en;
    logic [21:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [31:0] pre_data;
    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];

    resp_t       sb[$];
    int          n_checks;
    int          n_fail;
    logic        m_last;
    logic [15:0] m_lfsr;
    int          n_obs_grant;
    int          n_obs_rvalid;
    logic [31:0] seq;
    logic        obs_igrant;
    logic        obs_dgrant;
    logic        obs_dv;
    logic [31:0] obs_i_rdata;
    logic [31:0] obs_d_rdata;

    cv32e40p_tb_ram_arbiter #(
        .ADDR_WIDTH (22),
        .DATA_WIDTH (32),
        .STALL_SEED (32'hACE1),
        .STALL_MASK (4'b0011)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .data_req_i     (data_req),
        .data_addr_i    (data_addr),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .ram_en_o       (ram_en),
        .ram_addr_o     (ram_addr),
        .ram_we_o       (ram_we),
        .ram_be_o       (ram_be),
        .ram_wdata_o    (ram_wdata),
        .ram_rdata_i    (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM: read-before-write, 1-cycle latency, bench preload port
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (ram_en) begin
            ram_rdata <= mem[ram_addr[11:2]];
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare due response and predicted grant at the falling
    // edge, then advance the reference model past the rising edge.
    task automatic tick();
        resp_t       r;
        logic        exp_iv, exp_dv, exp_ig, exp_dg, stall;
        logic [31:0] exp_ird, exp_drd, exp_wdata;
        logic [21:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [9:0]  idx;
        @(negedge clk);
        if (rst) sb.delete();
        exp_iv = 1'b0; exp_dv = 1'b0; exp_ird = 32'h0; exp_drd = 32'h0;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            if (r.own) begin exp_dv = 1'b1; exp_drd = r.data; end
            else begin exp_iv = 1'b1; exp_ird = r.data; end
        end
        check_val("instr_rvalid", {31'h0, instr_rvalid}, {31'h0, exp_iv});
        check_val("data_rvalid", {31'h0, data_rvalid}, {31'h0, exp_dv});
        check_val("instr_rdata", instr_rdata, exp_ird);
        check_val("data_rdata", data_rdata, exp_drd);
        obs_dv = data_rvalid;
        if (instr_rvalid) begin n_obs_rvalid++; obs_i_rdata = instr_rdata; end
        if (data_rvalid)  begin n_obs_rvalid++; obs_d_rdata = data_rdata; end

        stall = 1'b0;
`ifdef TB_ARB_STALL_INJECT_EN
        stall = ((m_lfsr[3:0] & 4'b0011) != 4'b0000);
`endif
        exp_ig = 1'b0; exp_dg = 1'b0;
        if (!rst && !stall) begin
            if (instr_req && data_req) begin
                if (m_last) exp_ig = 1'b1; else exp_dg = 1'b1;
                m_last = exp_dg;
            end else if (instr_req) exp_ig = 1'b1;
            else if (data_req) exp_dg = 1'b1;
        end
        exp_addr = 22'h0; exp_we = 1'b0; exp_be = 4'h0; exp_wdata = 32'h0;
        if (exp_ig) begin
            exp_addr = {instr_addr[21:2], 2'b00}; exp_be = 4'hF;
        end else if (exp_dg) begin
            exp_addr = {data_addr[21:2], 2'b00}; exp_we = data_we;
            exp_be = data_be; exp_wdata = data_wdata;
        end
        check_val("instr_gnt", {31'h0, instr_gnt}, {31'h0, exp_ig});
        check_val("data_gnt", {31'h0, data_gnt}, {31'h0, exp_dg});
        check_val("ram_en", {31'h0, ram_en}, {31'h0, exp_ig | exp_dg});
        check_val("ram_addr", {10'h0, ram_addr}, {10'h0, exp_addr});
        check_val("ram_we", {31'h0, ram_we}, {31'h0, exp_we});
        check_val("ram_be", {28'h0, ram_be}, {28'h0, exp_be});
        check_val("ram_wdata", ram_wdata, exp_wdata);
        obs_igrant = instr_gnt;
        obs_dgrant = data_gnt;
        if (instr_gnt) begin n_obs_grant++; seq = seq << 1; end
        if (data_gnt)  begin n_obs_grant++; seq = (seq << 1) | 32'h1; end

        if (exp_ig) begin
            idx = instr_addr[11:2];
            sb.push_back('{own: 1'b0, data: ref_mem[idx]});
        end else if (exp_dg) begin
            idx = data_addr[11:2];
            if (data_we) begin
                sb.push_back('{own: 1'b1, data: 32'h0});
                for (int b = 0; b < 4; b++) begin
                    if (data_be[b]) ref_mem[idx][8*b +: 8] = data_wdata[8*b +: 8];
                end
            end else begin
                sb.push_back('{own: 1'b1, data: ref_mem[idx]});
            end
        end
        if (rst) begin
            m_last = 1'b0;
            m_lfsr = 16'hACE1;
        end else begin
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; instr_req = 1'b0; data_req = 1'b0;
        data_we = 1'b0; data_be = 4'h0; data_wdata = 32'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] val);
        pre_we = 1'b1; pre_idx = idx; pre_data = val;
        ref_mem[idx] = val;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic instr_access(input logic [21:0] addr);
        logic done;
        done = 1'b0;
        instr_req = 1'b1; instr_addr = addr;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            done = obs_igrant;
        end
        check_val("instr_gnt_timeout", {31'h0, done}, 32'h1);
        instr_req = 1'b0;
        tick();
    endtask

    task automatic data_access(input logic we, input logic [21:0] addr,
                               input logic [3:0] be, input logic [31:0] wdata);
        logic done;
        done = 1'b0;
        data_req = 1'b1; data_we = we; data_addr = addr; data_be = be; data_wdata = wdata;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            done = obs_dgrant;
        end
        check_val("data_gnt_timeout", {31'h0, done}, 32'h1);
        data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_wdata = 32'h0;
        tick();
    endtask

    initial begin
        int          base_g, base_v, ref_cnt;
        logic        done;
        logic [15:0] l;
        n_checks = 0; n_fail = 0; n_obs_grant = 0; n_obs_rvalid = 0;
        m_last = 1'b0; m_lfsr = 16'hACE1; seq = 32'h0;
        pre_we = 1'b0; pre_idx = 10'h0; pre_data = 32'h0; ram_rdata = 32'h0;
        instr_addr = 22'h0; data_addr = 22'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        do_reset();
        preload(10'h040, 32'hDEADBEEF);   // byte address 0x100
        preload(10'h080, 32'hFFFFFFFF);   // byte address 0x200
        do_reset();

        // instruction read of 0x100
        obs_i_rdata = 32'hBAD0BAD0;
        instr_access(22'h000100);
        check_val("fetch_rdata", obs_i_rdata, 32'hDEADBEEF);

        // partial store then load back
        obs_d_rdata = 32'hBAD0BAD0;
        data_access(1'b1, 22'h000202, 4'b0011, 32'h12345678);
        check_val("store_rdata", obs_d_rdata, 32'h0);
        obs_d_rdata = 32'hBAD0BAD0;
        data_access(1'b0, 22'h000200, 4'b1111, 32'h0);
        check_val("load_rdata", obs_d_rdata, 32'hFFFF5678);

        // both requesting from reset: strict alternation starting with data
        do_reset();
        instr_addr = 22'h000100; data_addr = 22'h000200; data_we = 1'b0; data_be = 4'hF;
        seq = 32'h0; base_g = n_obs_grant;
        instr_req = 1'b1; data_req = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        instr_req = 1'b0; data_req = 1'b0;
        tick();
`ifndef TB_ARB_STALL_INJECT_EN
        check_val("alt_seq", seq, 32'h0000002A);
        check_val("alt_count", n_obs_grant - base_g, 32'd6);
`endif

        // conflict winner only moves on conflicts
        do_reset();
        seq = 32'h0; base_g = n_obs_grant;
        instr_req = 1'b1; data_req = 1'b1; tick(); tick();
        data_req = 1'b0; tick(); tick(); tick();
        data_req = 1'b1; tick();
        data_req = 1'b0; tick(); tick();
        data_req = 1'b1; tick();
        instr_req = 1'b0; data_req = 1'b0; tick();
`ifndef TB_ARB_STALL_INJECT_EN
        check_val("conflict_seq", seq, 32'h00000108);
        check_val("conflict_count", n_obs_grant - base_g, 32'd9);
`endif

        // reset the cycle after a data grant drops the pending rvalid
        do_reset();
        done = 1'b0;
        data_req = 1'b1; data_addr = 22'h000200; data_we = 1'b0; data_be = 4'hF;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            done = obs_dgrant;
        end
        check_val("rst_setup_gnt", {31'h0, done}, 32'h1);
        data_req = 1'b0; rst = 1'b1;
        tick();
        check_val("rst_drop_rvalid", {31'h0, obs_dv}, 32'h0);
        tick();
        rst = 1'b0;
        instr_req = 1'b1; data_req = 1'b1; done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            done = obs_igrant | obs_dgrant;
        end
        check_val("post_rst_conflict_d", {31'h0, obs_dgrant}, 32'h1);
        check_val("post_rst_conflict_i", {31'h0, obs_igrant}, 32'h0);
        instr_req = 1'b0; data_req = 1'b0;
        tick();

        // instr held for 64 cycles from reset: grant count vs stall pattern
        do_reset();
        ref_cnt = 0;
        l = 16'hACE1;
        for (int i = 0; i < 64; i++) begin
`ifdef TB_ARB_STALL_INJECT_EN
            if ((l[3:0] & 4'b0011) == 4'b0000) ref_cnt++;
`else
            ref_cnt++;
`endif
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end
        base_g = n_obs_grant; base_v = n_obs_rvalid;
        instr_req = 1'b1; instr_addr = 22'h000100;
        for (int i = 0; i < 64; i++) tick();
        instr_req = 1'b0;
        tick();
        check_val("hold_grant_count", n_obs_grant - base_g, ref_cnt);
        check_val("hold_rvalid_count", n_obs_rvalid - base_v, ref_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
